rx_byte_fifo: RTL and testbench

RX_BYTE_FIFO -- requirements
Module: rx_byte_fifo

---
 rtl/rx_byte_fifo.sv | 107 ++++++++++
 tb/tb_rx_byte_fifo.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_byte_fifo.sv
// Receive-side byte FIFO behind the Uart8 receiver.
// Captures each rising edge of rxDone as one byte, drops bytes flagged by rxErr,
// counts error pulses, and records when a byte is lost because the FIFO is full.
module rx_byte_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rxDone,
    input  logic                  rxErr,
    input  logic [7:0]            in,
    input  logic                  readEn,
    input  logic                  clearFlags,
    output logic [7:0]            out,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic [7:0]            errCount
);

    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam int unsigned PTR_W  = DEPTH_LOG2;
    localparam int unsigned CNT_W  = DEPTH_LOG2 + 1;
    localparam int unsigned DATA_W = 8;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic              donePrev;
    logic              errPrev;

    logic wrStrobe;
    logic pop;
    logic doWrite;
    logic drop;
    logic errEdge;

    // Status is decoded from the registered count; out is the show-ahead head entry.
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign out   = mem[rdPtr];

    // Event decode: a byte is taken only on a clean rxDone rising edge.
    always_comb begin
        wrStrobe = rxDone & ~donePrev & ~rxErr;
        pop      = readEn & ~empty;
        doWrite  = wrStrobe & (~full | pop);
        drop     = wrStrobe & full & ~pop;
        errEdge  = rxErr & ~errPrev;
    end

    // Byte storage; left uninitialised since the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (!reset && doWrite) begin
            mem[wrPtr] <= in;
        end
    end

    // Pointers, occupancy, edge-detect history and sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            // History starts high so levels held through reset release are not edges.
            donePrev <= 1'b1;
            errPrev  <= 1'b1;
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
            errCount <= '0;
        end else begin
            donePrev <= rxDone;
            errPrev  <= rxErr;

            if (doWrite) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end

            unique case ({doWrite, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            // A set event in the same cycle as clearFlags takes precedence.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clearFlags) begin
                overflow <= 1'b0;
            end

            if (errEdge) begin
                if (clearFlags) begin
                    errCount <= 8'd1;
                end else if (errCount != 8'hFF) begin
                    errCount <= errCount + 8'd1;
                end
            end else if (clearFlags) begin
                errCount <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Bench for rx_byte_fifo: a cycle table for the basic paths, then scoreboarded
// sequences for fill/overflow, full write+pop, pointer wrap, errors and reset.
module tb_rx_byte_fifo;

    localparam int unsigned DEPTH_LOG2 = 4;
    localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;
    localparam int unsigned NVEC       = 18;

    logic                clk;
    logic                reset;
    logic                rxDone;
    logic                rxErr;
    logic [7:0]          in;
    logic                readEn;
    logic                clearFlags;
    logic [7:0]          out;
    logic                empty;
    logic                full;
    logic [DEPTH_LOG2:0] count;
    logic                overflow;
    logic [7:0]          errCount;

    int errors = 0;
    int checks = 0;
    logic [7:0] sb[$];

    typedef struct {
        logic       done;
        logic       err;
        logic       rd;
        logic       clr;
        logic [7:0] din;
        int         expCount;
        logic       expEmpty;
        logic       chkOut;
        logic [7:0] expOut;
        int         expErrCnt;
    } vec_t;

    vec_t vecs [NVEC];

    rx_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk        (clk),
        .reset      (reset),
        .rxDone     (rxDone),
        .rxErr      (rxErr),
        .in         (in),
        .readEn     (readEn),
        .clearFlags (clearFlags),
        .out        (out),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .overflow   (overflow),
        .errCount   (errCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1; rxDone = 1'b0; rxErr = 1'b0; in = 8'h00;
        readEn = 1'b0; clearFlags = 1'b0;
        step();
        step();
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic writeByte(input logic [7:0] b);
        rxDone = 1'b1; in = b;
        step();
        rxDone = 1'b0;
        step();
        if (sb.size() < DEPTH) sb.push_back(b);
        check("write_count", int'(count), sb.size());
    endtask

    task automatic popByte();
        logic [7:0] exp;
        check("pop_not_empty", int'(empty), 0);
        if (sb.size() == 0) begin
            check("pop_scoreboard_nonempty", 0, 1);
        end else begin
            exp = sb.pop_front();
            check("pop_data", int'(out), int'(exp));
        end
        readEn = 1'b1;
        step();
        readEn = 1'b0;
        check("pop_count", int'(count), sb.size());
    endtask

    task automatic errPulse(input logic withDone, input logic [7:0] b);
        rxErr = 1'b1; rxDone = withDone; in = b;
        step();
        rxErr = 1'b0; rxDone = 1'b0;
        step();
    endtask

    initial begin
        // done err rd clr din  cnt empty chkOut out errCnt
        vecs[0]  = '{0, 0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0};
        vecs[1]  = '{1, 0, 0, 0, 8'hD6, 1, 0, 1, 8'hD6, 0};
        vecs[2]  = '{1, 0, 0, 0, 8'hD6, 1, 0, 1, 8'hD6, 0};
        vecs[3]  = '{1, 0, 0, 0, 8'hD6, 1, 0, 1, 8'hD6, 0};
        vecs[4]  = '{0, 0, 0, 0, 8'h00, 1, 0, 1, 8'hD6, 0};
        vecs[5]  = '{1, 0, 0, 0, 8'h3C, 2, 0, 1, 8'hD6, 0};
        vecs[6]  = '{0, 0, 1, 0, 8'h00, 1, 0, 1, 8'h3C, 0};
        vecs[7]  = '{0, 1, 0, 0, 8'h00, 1, 0, 1, 8'h3C, 1};
        vecs[8]  = '{1, 1, 0, 0, 8'h77, 1, 0, 1, 8'h3C, 1};
        vecs[9]  = '{0, 0, 0, 0, 8'h00, 1, 0, 1, 8'h3C, 1};
        vecs[10] = '{0, 1, 0, 0, 8'h00, 1, 0, 1, 8'h3C, 2};
        vecs[11] = '{0, 0, 0, 0, 8'h00, 1, 0, 1, 8'h3C, 2};
        vecs[12] = '{0, 1, 0, 1, 8'h00, 1, 0, 1, 8'h3C, 1};
        vecs[13] = '{0, 0, 0, 1, 8'h00, 1, 0, 1, 8'h3C, 0};
        vecs[14] = '{0, 0, 1, 0, 8'h00, 0, 1, 0, 8'h00, 0};
        vecs[15] = '{0, 0, 1, 0, 8'h00, 0, 1, 0, 8'h00, 0};
        vecs[16] = '{1, 0, 1, 0, 8'h99, 1, 0, 1, 8'h99, 0};
        vecs[17] = '{0, 0, 1, 0, 8'h00, 0, 1, 0, 8'h00, 0};

        doReset();
        check("reset_count", int'(count), 0);
        check("reset_empty", int'(empty), 1);
        check("reset_full", int'(full), 0);
        check("reset_overflow", int'(overflow), 0);
        check("reset_errCount", int'(errCount), 0);

        // Cycle table: single byte, held rxDone, rxErr discard, flag clearing, empty pop.
        for (int i = 0; i < int'(NVEC); i++) begin
            rxDone = vecs[i].done; rxErr = vecs[i].err; readEn = vecs[i].rd;
            clearFlags = vecs[i].clr; in = vecs[i].din;
            step();
            check($sformatf("vec%0d_count", i), int'(count), vecs[i].expCount);
            check($sformatf("vec%0d_empty", i), int'(empty), int'(vecs[i].expEmpty));
            check($sformatf("vec%0d_errCount", i), int'(errCount), vecs[i].expErrCnt);
            if (vecs[i].chkOut) check($sformatf("vec%0d_out", i), int'(out), int'(vecs[i].expOut));
        end
        rxDone = 1'b0; rxErr = 1'b0; readEn = 1'b0; clearFlags = 1'b0;

        // Fill, overflow drop, clear/set precedence on overflow, drain in order.
        doReset();
        step();
        for (int i = 0; i < int'(DEPTH); i++) writeByte(8'(i));
        check("fill_full", int'(full), 1);
        check("fill_overflow_clear", int'(overflow), 0);
        writeByte(8'h55);
        check("ovf_full", int'(full), 1);
        check("ovf_count", int'(count), int'(DEPTH));
        check("ovf_overflow", int'(overflow), 1);
        clearFlags = 1'b1;
        step();
        clearFlags = 1'b0;
        check("ovf_cleared", int'(overflow), 0);
        check("ovf_clear_keeps_count", int'(count), int'(DEPTH));
        clearFlags = 1'b1; rxDone = 1'b1; in = 8'h66;
        step();
        clearFlags = 1'b0; rxDone = 1'b0;
        check("ovf_set_wins", int'(overflow), 1);
        step();
        for (int i = 0; i < int'(DEPTH); i++) popByte();
        check("drain_empty", int'(empty), 1);

        // Full with simultaneous write and pop: count holds, no overflow, new byte last.
        doReset();
        step();
        for (int i = 0; i < int'(DEPTH); i++) writeByte(8'h40 + 8'(i));
        if (sb.size() != 0) check("fullwp_head", int'(out), int'(sb[0]));
        void'(sb.pop_front());
        sb.push_back(8'hAA);
        rxDone = 1'b1; in = 8'hAA; readEn = 1'b1;
        step();
        rxDone = 1'b0; readEn = 1'b0;
        check("fullwp_count", int'(count), int'(DEPTH));
        check("fullwp_overflow", int'(overflow), 0);
        check("fullwp_full", int'(full), 1);
        step();
        for (int i = 0; i < int'(DEPTH); i++) popByte();
        check("fullwp_empty", int'(empty), 1);

        // Pointer wrap: 20 write/pop pairs starting from a non-zero pointer offset.
        for (int i = 0; i < 20; i++) begin
            writeByte(8'h10 + 8'(i));
            popByte();
        end
        check("wrap_empty", int'(empty), 1);

        // Error counting, byte discard with rxErr, clear and saturation.
        doReset();
        step();
        errPulse(1'b0, 8'h00);
        errPulse(1'b1, 8'h77);
        errPulse(1'b0, 8'h00);
        check("err_count3", int'(errCount), 3);
        check("err_no_store", int'(count), 0);
        check("err_empty", int'(empty), 1);
        clearFlags = 1'b1;
        step();
        clearFlags = 1'b0;
        check("err_cleared", int'(errCount), 0);
        for (int i = 0; i < 300; i++) errPulse(1'b0, 8'h00);
        check("err_saturate", int'(errCount), 255);

        // Reset mid-operation with rxDone held high across release.
        doReset();
        step();
        for (int i = 0; i < 5; i++) writeByte(8'hC0 + 8'(i));
        check("mid_count5", int'(count), 5);
        rxDone = 1'b1; in = 8'hEE; reset = 1'b1;
        step();
        reset = 1'b0;
        sb.delete();
        check("mid_reset_count", int'(count), 0);
        check("mid_reset_empty", int'(empty), 1);
        for (int i = 0; i < 3; i++) step();
        check("mid_held_no_write", int'(count), 0);
        rxDone = 1'b0;
        step();
        rxDone = 1'b1;
        step();
        check("mid_rewrite_count", int'(count), 1);
        check("mid_rewrite_out", int'(out), 8'hEE);
        rxDone = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
